// File: rtl/sdram_rd_data_checker.sv
// Read-back checker for SDRAM traffic: follows each read burst, compares returned words
// against an incrementing pattern, and keeps error counts plus first-failure details.
module sdram_rd_data_checker #(
  parameter logic [2:0]  BURST_LEN  = 3'b000,
  parameter int          ADDR_WIDTH = 24,
  parameter logic [15:0] EXP_START  = 16'd2,
  parameter logic [15:0] EXP_STEP   = 16'd2,
  parameter logic [15:0] NUM_BURSTS = 16'd512
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_data_valid,
  input  logic [15:0]           i_rd_data,
  input  logic                  i_rd_done,
  output logic                  o_busy,
  output logic                  o_burst_ok,
  output logic                  o_err_pulse,
  output logic                  o_err_sticky,
  output logic [15:0]           o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic [15:0]           o_first_err_exp,
  output logic [15:0]           o_first_err_got,
  output logic                  o_test_done,
  output logic [1:0]            o_dbg_state
);

  localparam int BL = (BURST_LEN == 3'b001) ? 2 :
                      (BURST_LEN == 3'b010) ? 4 :
                      (BURST_LEN == 3'b011) ? 8 : 1;
  localparam logic [3:0] LAST_IDX = 4'(BL - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [3:0]            r_beat_idx;
  logic [15:0]           r_exp;
  logic [15:0]           r_burst_cnt;
  logic                  r_burst_err;
  logic                  r_busy, r_burst_ok, r_err_pulse, r_err_sticky, r_test_done;
  logic [15:0]           r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic [15:0]           r_first_err_exp, r_first_err_got;

  logic                  w_start, w_beat, w_beat_err, w_under, w_over, w_close;
  logic [1:0]            w_n_err;
  logic                  w_any_err;
  logic [16:0]           w_cnt_sum;
  logic [3:0]            w_under_idx;
  logic [ADDR_WIDTH-1:0] w_cap_addr;
  logic [15:0]           w_cap_exp, w_cap_got;

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_beat     = 1'b0;
    w_beat_err = 1'b0;
    w_under    = 1'b0;
    w_over     = 1'b0;
    w_close    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rd_req) begin
          w_start = 1'b1;
          w_next  = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (i_rd_data_valid) begin
          w_beat     = 1'b1;
          w_beat_err = (i_rd_data != r_exp);
        end
        if (i_rd_data_valid && (r_beat_idx == LAST_IDX)) begin
          if (i_rd_done) w_close = 1'b1;
          else           w_next  = S_WAIT_DONE;
        end else if (i_rd_done) begin
          w_under = 1'b1;
          w_close = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        w_over  = i_rd_data_valid;
        w_close = i_rd_done;
      end
      default: ;
    endcase
    if (w_close)
      w_next = ((r_burst_cnt + 16'd1) == NUM_BURSTS) ? S_DONE : S_IDLE;
  end

  // A short burst with a valid beat on the rd_done cycle can log two errors at once.
  assign w_n_err     = {1'b0, w_beat_err} + {1'b0, w_under} + {1'b0, w_over};
  assign w_any_err   = (w_n_err != 2'd0);
  assign w_cnt_sum   = {1'b0, r_err_count} + {15'd0, w_n_err};
  assign w_under_idx = r_beat_idx + {3'd0, w_beat};

  always_comb begin
    w_cap_addr = r_base + ADDR_WIDTH'(r_beat_idx);
    w_cap_exp  = r_exp;
    w_cap_got  = i_rd_data;
    if (!w_beat_err && w_under) begin
      w_cap_addr = r_base + ADDR_WIDTH'(w_under_idx);
      w_cap_exp  = w_beat ? (r_exp + EXP_STEP) : r_exp;
      w_cap_got  = 16'h0000;
    end else if (w_over) begin
      w_cap_addr = r_base + ADDR_WIDTH'(BL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_base           <= '0;
      r_beat_idx       <= 4'd0;
      r_exp            <= EXP_START;
      r_burst_cnt      <= 16'd0;
      r_burst_err      <= 1'b0;
      r_busy           <= 1'b0;
      r_burst_ok       <= 1'b0;
      r_err_pulse      <= 1'b0;
      r_err_sticky     <= 1'b0;
      r_test_done      <= 1'b0;
      r_err_count      <= 16'd0;
      r_first_err_addr <= '0;
      r_first_err_exp  <= 16'd0;
      r_first_err_got  <= 16'd0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next == S_WAIT_DATA) || (w_next == S_WAIT_DONE);
      r_test_done <= (w_next == S_DONE);
      r_err_pulse <= w_any_err;
      r_burst_ok  <= w_close && !r_burst_err && !w_any_err;
      if (w_start) begin
        r_base      <= i_rd_addr;
        r_beat_idx  <= 4'd0;
        r_burst_err <= 1'b0;
      end
      if (w_beat) begin
        r_exp      <= r_exp + EXP_STEP;
        r_beat_idx <= r_beat_idx + 4'd1;
      end
      if (w_any_err) begin
        r_burst_err  <= 1'b1;
        r_err_sticky <= 1'b1;
        r_err_count  <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        if (!r_err_sticky) begin
          r_first_err_addr <= w_cap_addr;
          r_first_err_exp  <= w_cap_exp;
          r_first_err_got  <= w_cap_got;
        end
      end
      if (w_close) r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

  assign o_busy           = r_busy;
  assign o_burst_ok       = r_burst_ok;
  assign o_err_pulse      = r_err_pulse;
  assign o_err_sticky     = r_err_sticky;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;
  assign o_first_err_exp  = r_first_err_exp;
  assign o_first_err_got  = r_first_err_got;
  assign o_test_done      = r_test_done;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_sdram_rd_data_checker.sv
// Directed bench for sdram_rd_data_checker: three instances (BL=4 with 3 bursts, BL=8, BL=2)
// driven independently; expected values are hand-computed constants.
module tb_sdram_rd_data_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, rd_req, rd_valid, rd_done;
  logic [2:0][23:0] rd_addr;
  logic [2:0][15:0] rd_data;
  logic [2:0]       busy, burst_ok, err_pulse, err_sticky, test_done;
  logic [2:0][15:0] err_count, fe_exp, fe_got;
  logic [2:0][23:0] fe_addr;
  logic [2:0][1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_rd_data_checker #(.BURST_LEN(3'b010), .NUM_BURSTS(16'd3)) u_bl4 (
    .i_clk(clk), .i_rst(rst[0]), .i_rd_req(rd_req[0]), .i_rd_addr(rd_addr[0]),
    .i_rd_data_valid(rd_valid[0]), .i_rd_data(rd_data[0]), .i_rd_done(rd_done[0]),
    .o_busy(busy[0]), .o_burst_ok(burst_ok[0]), .o_err_pulse(err_pulse[0]),
    .o_err_sticky(err_sticky[0]), .o_err_count(err_count[0]), .o_first_err_addr(fe_addr[0]),
    .o_first_err_exp(fe_exp[0]), .o_first_err_got(fe_got[0]), .o_test_done(test_done[0]),
    .o_dbg_state(dbg_state[0]));

  sdram_rd_data_checker #(.BURST_LEN(3'b011)) u_bl8 (
    .i_clk(clk), .i_rst(rst[1]), .i_rd_req(rd_req[1]), .i_rd_addr(rd_addr[1]),
    .i_rd_data_valid(rd_valid[1]), .i_rd_data(rd_data[1]), .i_rd_done(rd_done[1]),
    .o_busy(busy[1]), .o_burst_ok(burst_ok[1]), .o_err_pulse(err_pulse[1]),
    .o_err_sticky(err_sticky[1]), .o_err_count(err_count[1]), .o_first_err_addr(fe_addr[1]),
    .o_first_err_exp(fe_exp[1]), .o_first_err_got(fe_got[1]), .o_test_done(test_done[1]),
    .o_dbg_state(dbg_state[1]));

  sdram_rd_data_checker #(.BURST_LEN(3'b001)) u_bl2 (
    .i_clk(clk), .i_rst(rst[2]), .i_rd_req(rd_req[2]), .i_rd_addr(rd_addr[2]),
    .i_rd_data_valid(rd_valid[2]), .i_rd_data(rd_data[2]), .i_rd_done(rd_done[2]),
    .o_busy(busy[2]), .o_burst_ok(burst_ok[2]), .o_err_pulse(err_pulse[2]),
    .o_err_sticky(err_sticky[2]), .o_err_count(err_count[2]), .o_first_err_addr(fe_addr[2]),
    .o_first_err_exp(fe_exp[2]), .o_first_err_got(fe_got[2]), .o_test_done(test_done[2]),
    .o_dbg_state(dbg_state[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int d, input logic [23:0] addr);
    rd_req[d]  = 1'b1;
    rd_addr[d] = addr;
    tick();
  endtask

  task automatic send_beat(input int d, input logic [15:0] data);
    rd_valid[d] = 1'b1;
    rd_data[d]  = data;
    tick();
    rd_valid[d] = 1'b0;
  endtask

  task automatic send_done(input int d);
    rd_done[d] = 1'b1;
    tick();
    rd_done[d] = 1'b0;
    rd_req[d]  = 1'b0;
  endtask

  task automatic hold_reset(input int d);
    rst[d]      = 1'b1;
    rd_req[d]   = 1'b0;
    rd_valid[d] = 1'b0;
    rd_done[d]  = 1'b0;
    tick();
  endtask

  initial begin
    rst = 3'b111; rd_req = '0; rd_valid = '0; rd_done = '0; rd_addr = '0; rd_data = '0;
    tick(); tick();
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_state", 32'(dbg_state[0]), 32'd0);
    check("rst_cnt", 32'(err_count[0]), 32'd0);
    check("rst_done", 32'(test_done[0]), 32'd0);
    rst = 3'b000;
    tick();

    // BL=4: three clean bursts; pattern continues 2..8, 10..16, 18..24
    start_burst(0, 24'h000100);
    check("b1_busy", 32'(busy[0]), 32'd1);
    send_beat(0, 16'd2); send_beat(0, 16'd4); send_beat(0, 16'd6); send_beat(0, 16'd8);
    check("b1_pulse", 32'(err_pulse[0]), 32'd0);
    check("b1_wait_done", 32'(dbg_state[0]), 32'd2);
    send_done(0);
    check("b1_ok", 32'(burst_ok[0]), 32'd1);
    check("b1_cnt", 32'(err_count[0]), 32'd0);
    check("b1_idle", 32'(busy[0]), 32'd0);
    tick();
    check("b1_ok_1cyc", 32'(burst_ok[0]), 32'd0);
    start_burst(0, 24'h000104);
    send_beat(0, 16'd10); send_beat(0, 16'd12); send_beat(0, 16'd14); send_beat(0, 16'd16);
    send_done(0);
    check("b2_ok", 32'(burst_ok[0]), 32'd1);
    check("b2_sticky", 32'(err_sticky[0]), 32'd0);
    check("b2_not_done", 32'(test_done[0]), 32'd0);
    start_burst(0, 24'h000108);
    send_beat(0, 16'd18); send_beat(0, 16'd20); send_beat(0, 16'd22); send_beat(0, 16'd24);
    send_done(0);
    check("b3_ok", 32'(burst_ok[0]), 32'd1);
    check("b3_test_done", 32'(test_done[0]), 32'd1);
    start_burst(0, 24'h000200);
    send_beat(0, 16'd99);
    tick(); tick();
    check("done_hold", 32'(test_done[0]), 32'd1);
    check("done_ignore_req", 32'(busy[0]), 32'd0);
    check("done_state", 32'(dbg_state[0]), 32'd3);
    check("done_no_err", 32'(err_count[0]), 32'd0);

    // reset mid-burst, then the pattern restarts at 2
    hold_reset(0);
    rst[0] = 1'b0;
    start_burst(0, 24'h000300);
    send_beat(0, 16'd2); send_beat(0, 16'd4);
    check("mid_busy", 32'(busy[0]), 32'd1);
    hold_reset(0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_done", 32'(test_done[0]), 32'd0);
    check("mid_rst_state", 32'(dbg_state[0]), 32'd0);
    rst[0] = 1'b0;
    start_burst(0, 24'h000300);
    send_beat(0, 16'd2); send_beat(0, 16'd4); send_beat(0, 16'd6); send_beat(0, 16'd8);
    send_done(0);
    check("mid_restart_ok", 32'(burst_ok[0]), 32'd1);
    check("mid_restart_cnt", 32'(err_count[0]), 32'd0);

    // BL=4 data mismatch on third beat
    hold_reset(0);
    rst[0] = 1'b0;
    start_burst(0, 24'h000100);
    send_beat(0, 16'd2); send_beat(0, 16'd4);
    check("mm_no_pulse", 32'(err_pulse[0]), 32'd0);
    send_beat(0, 16'd7);
    check("mm_pulse", 32'(err_pulse[0]), 32'd1);
    check("mm_addr", 32'(fe_addr[0]), 32'h000102);
    check("mm_exp", 32'(fe_exp[0]), 32'd6);
    check("mm_got", 32'(fe_got[0]), 32'd7);
    check("mm_cnt", 32'(err_count[0]), 32'd1);
    send_beat(0, 16'd8);
    check("mm_pulse_clear", 32'(err_pulse[0]), 32'd0);
    send_done(0);
    check("mm_no_ok", 32'(burst_ok[0]), 32'd0);
    check("mm_sticky", 32'(err_sticky[0]), 32'd1);

    // BL=8 underrun after 5 beats
    start_burst(1, 24'h000200);
    send_beat(1, 16'd2); send_beat(1, 16'd4); send_beat(1, 16'd6);
    send_beat(1, 16'd8); send_beat(1, 16'd10);
    check("ur_no_pulse", 32'(err_pulse[1]), 32'd0);
    send_done(1);
    check("ur_pulse", 32'(err_pulse[1]), 32'd1);
    check("ur_no_ok", 32'(burst_ok[1]), 32'd0);
    check("ur_cnt", 32'(err_count[1]), 32'd1);
    check("ur_got", 32'(fe_got[1]), 32'd0);
    check("ur_exp", 32'(fe_exp[1]), 32'd12);
    check("ur_addr", 32'(fe_addr[1]), 32'h000205);
    check("ur_idle", 32'(dbg_state[1]), 32'd0);

    // BL=2 overrun, then a second error that must not overwrite the first capture
    start_burst(2, 24'h000300);
    send_beat(2, 16'd2); send_beat(2, 16'd4);
    check("or_wait_done", 32'(dbg_state[2]), 32'd2);
    send_beat(2, 16'd6);
    check("or_pulse", 32'(err_pulse[2]), 32'd1);
    check("or_cnt", 32'(err_count[2]), 32'd1);
    check("or_sticky", 32'(err_sticky[2]), 32'd1);
    check("or_addr", 32'(fe_addr[2]), 32'h000302);
    check("or_exp", 32'(fe_exp[2]), 32'd6);
    check("or_got", 32'(fe_got[2]), 32'd6);
    send_done(2);
    check("or_no_ok", 32'(burst_ok[2]), 32'd0);
    start_burst(2, 24'h000400);
    send_beat(2, 16'd6); send_beat(2, 16'd9);
    check("e2_pulse", 32'(err_pulse[2]), 32'd1);
    check("e2_cnt", 32'(err_count[2]), 32'd2);
    check("e2_keep_addr", 32'(fe_addr[2]), 32'h000302);
    check("e2_keep_got", 32'(fe_got[2]), 32'd6);
    send_done(2);
    check("e2_no_ok", 32'(burst_ok[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
